// File: rtl/sysp_icb_fanout.sv
// ICB slave that fans one command at a time out to NSLOT peripheral register ports,
// with per-slot wait states, error responses for unmapped slots and a wait timeout.
module sysp_icb_fanout #(
    parameter int unsigned NSLOT   = 16,
    parameter int unsigned SLOT_AW = 8,
    parameter logic [31:0] SLOT_EN = 32'h800F,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sysp_icb_cmd_valid,
    output logic                  sysp_icb_cmd_ready,
    input  logic [31:0]           sysp_icb_cmd_addr,
    input  logic                  sysp_icb_cmd_read,
    input  logic [31:0]           sysp_icb_cmd_wdata,
    input  logic [3:0]            sysp_icb_cmd_wmask,
    output logic                  sysp_icb_rsp_valid,
    input  logic                  sysp_icb_rsp_ready,
    output logic                  sysp_icb_rsp_err,
    output logic [31:0]           sysp_icb_rsp_rdata,
    output logic [SLOT_AW-1:0]    per_waddr,
    output logic [SLOT_AW-1:0]    per_raddr,
    output logic [31:0]           per_wdata,
    output logic [3:0]            per_sel,
    output logic [NSLOT-1:0]      per_we,
    output logic [NSLOT-1:0]      per_rd,
    input  logic [NSLOT-1:0]      per_wait,
    input  logic [NSLOT*32-1:0]   per_rdata
);

    localparam int unsigned SW = $clog2(NSLOT);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   slot_r;
    logic            read_r;
    logic [TO_W-1:0] wait_cnt;

    logic [SW-1:0]    cmd_slot;
    logic             cmd_mapped;
    logic             accept;
    logic [NSLOT-1:0] slot_onehot;
    logic [DW-1:0]    slot_rdata;
    logic             timeout_hit;

    // Address bits outside the slot decode are resolved upstream
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sysp_icb_cmd_addr[AW-1:SLOT_AW+SW], sysp_icb_cmd_addr[1:0]};

    // Command decode; strobes fire in the accept cycle and never while in reset
    assign cmd_slot    = sysp_icb_cmd_addr[SLOT_AW+SW-1:SLOT_AW];
    assign cmd_mapped  = SLOT_EN[cmd_slot];
    assign accept      = rst_n && (state == IDLE) && sysp_icb_cmd_valid;
    assign slot_onehot = NSLOT'(1) << cmd_slot;

    assign sysp_icb_cmd_ready = rst_n && (state == IDLE);
    assign per_we    = (accept && cmd_mapped && !sysp_icb_cmd_read) ? slot_onehot : '0;
    assign per_rd    = (accept && cmd_mapped &&  sysp_icb_cmd_read) ? slot_onehot : '0;
    assign per_waddr = {sysp_icb_cmd_addr[SLOT_AW-1:2], 2'b00};
    assign per_raddr = {sysp_icb_cmd_addr[SLOT_AW-1:2], 2'b00};
    assign per_wdata = sysp_icb_cmd_wdata;
    assign per_sel   = sysp_icb_cmd_wmask;

    // Selected slot's read data and timeout detection for the latched slot
    assign slot_rdata  = per_rdata[{slot_r, 5'd0} +: DW];
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT - 1));

    // Transaction FSM with registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            slot_r             <= '0;
            read_r             <= 1'b0;
            wait_cnt           <= '0;
            sysp_icb_rsp_valid <= 1'b0;
            sysp_icb_rsp_err   <= 1'b0;
            sysp_icb_rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sysp_icb_cmd_valid) begin
                        slot_r   <= cmd_slot;
                        read_r   <= sysp_icb_cmd_read;
                        wait_cnt <= '0;
                        if (cmd_mapped) begin
                            state <= WAIT;
                        end else begin
                            sysp_icb_rsp_err   <= 1'b1;
                            sysp_icb_rsp_rdata <= '0;
                            sysp_icb_rsp_valid <= 1'b1;
                            state              <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!per_wait[slot_r]) begin
                        sysp_icb_rsp_rdata <= read_r ? slot_rdata : '0;
                        sysp_icb_rsp_err   <= 1'b0;
                        sysp_icb_rsp_valid <= 1'b1;
                        state              <= RESP;
                    end else if (timeout_hit) begin
                        sysp_icb_rsp_rdata <= '0;
                        sysp_icb_rsp_err   <= 1'b1;
                        sysp_icb_rsp_valid <= 1'b1;
                        state              <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                RESP: begin
                    if (sysp_icb_rsp_ready) begin
                        sysp_icb_rsp_valid <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: begin
                    sysp_icb_rsp_valid <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysp_icb_fanout.sv
// Scoreboard bench for sysp_icb_fanout: directed commands push expected responses,
// a negedge monitor checks each response as it appears.
module tb_sysp_icb_fanout;

    localparam int unsigned NSLOT   = 16;
    localparam int unsigned SLOT_AW = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_addr;
    logic                  cmd_read;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;
    logic [SLOT_AW-1:0]    per_waddr;
    logic [SLOT_AW-1:0]    per_raddr;
    logic [31:0]           per_wdata;
    logic [3:0]            per_sel;
    logic [NSLOT-1:0]      per_we;
    logic [NSLOT-1:0]      per_rd;
    logic [NSLOT-1:0]      per_wait;
    logic [NSLOT*32-1:0]   per_rdata;

    sysp_icb_fanout #(
        .NSLOT(NSLOT), .SLOT_AW(SLOT_AW), .SLOT_EN(32'h800F), .TIMEOUT(4), .TO_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sysp_icb_cmd_valid(cmd_valid), .sysp_icb_cmd_ready(cmd_ready),
        .sysp_icb_cmd_addr(cmd_addr), .sysp_icb_cmd_read(cmd_read),
        .sysp_icb_cmd_wdata(cmd_wdata), .sysp_icb_cmd_wmask(cmd_wmask),
        .sysp_icb_rsp_valid(rsp_valid), .sysp_icb_rsp_ready(rsp_ready),
        .sysp_icb_rsp_err(rsp_err), .sysp_icb_rsp_rdata(rsp_rdata),
        .per_waddr(per_waddr), .per_raddr(per_raddr), .per_wdata(per_wdata),
        .per_sel(per_sel), .per_we(per_we), .per_rd(per_rd),
        .per_wait(per_wait), .per_rdata(per_rdata)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: compares the first cycle of each response against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_err",   64'(rsp_err),   64'(e.err));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_cycle", 64'(cyc),       64'(e.cyc));
            end
        end
        prev_valid = rst_n && rsp_valid;
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready && !rsp_valid && exp_q.size() == 0) break;
        end
        if (k == 50) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Issue one command; checks strobes and address fan-out in the accept cycle
    task automatic do_cmd(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic exp_err, input logic [31:0] exp_rdata,
                          input int lat, input logic [15:0] exp_we, input logic [15:0] exp_rd,
                          input logic push);
        exp_t e;
        logic [7:0] off;
        off = {addr[7:2], 2'b00};
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_read  = rd;
        cmd_wdata = wdata;
        cmd_wmask = wmask;
        @(negedge clk);
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        chk("per_we",    64'(per_we),    64'(exp_we));
        chk("per_rd",    64'(per_rd),    64'(exp_rd));
        chk("per_waddr", 64'(per_waddr), 64'(off));
        chk("per_raddr", 64'(per_raddr), 64'(off));
        chk("per_sel",   64'(per_sel),   64'(wmask));
        chk("per_wdata", 64'(per_wdata), 64'(wdata));
        if (push) begin
            e.err   = exp_err;
            e.rdata = exp_rdata;
            e.cyc   = cyc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("strobe_pulse", 64'({per_we, per_rd}), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_read  = 1'b0;
        cmd_wdata = '0;
        cmd_wmask = '0;
        rsp_ready = 1'b1;
        per_wait  = '0;
        per_rdata = '0;
        per_rdata[0*32 +: 32]  = 32'hA5A5_0001;
        per_rdata[1*32 +: 32]  = 32'h1111_1111;
        per_rdata[2*32 +: 32]  = 32'h0000_1234;
        per_rdata[15*32 +: 32] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Mapped read, no wait
        do_cmd(32'h0000_0004, 1'b1, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 2, 16'h0000, 16'h0001, 1'b1);
        wait_idle();
        // Mapped write to top slot: no read data returned
        do_cmd(32'h0000_0F08, 1'b0, 32'h55AA_1234, 4'b0011, 1'b0, 32'h0, 2, 16'h8000, 16'h0000, 1'b1);
        wait_idle();
        // Unmapped read and write
        do_cmd(32'h0000_0504, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 1, 16'h0000, 16'h0000, 1'b1);
        wait_idle();
        do_cmd(32'h0000_0400, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1, 16'h0000, 16'h0000, 1'b1);
        wait_idle();

        // Three wait cycles on slot 2
        per_wait[2] = 1'b1;
        do_cmd(32'h0000_0200, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0000_1234, 5, 16'h0000, 16'h0004, 1'b1);
        repeat (3) @(posedge clk);
        #1 per_wait[2] = 1'b0;
        wait_idle();

        // Stuck slot 1 times out
        per_wait[1] = 1'b1;
        do_cmd(32'h0000_0110, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 5, 16'h0000, 16'h0002, 1'b1);
        wait_idle();
        per_wait[1] = 1'b0;
        do_cmd(32'h0000_01FC, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111, 2, 16'h0000, 16'h0002, 1'b1);
        wait_idle();

        // High address bits ignored
        do_cmd(32'hFFFF_FF0C, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 2, 16'h0000, 16'h8000, 1'b1);
        wait_idle();

        // Response back-pressure while a new command is pending
        rsp_ready = 1'b0;
        do_cmd(32'h0000_0008, 1'b1, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 2, 16'h0000, 16'h0001, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0F00;
        cmd_read  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_strobes",   64'({per_we, per_rd}), 64'd0);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
            chk("hold_rsp_err",   64'(rsp_err),   64'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while waiting on slot 1
        per_wait[1] = 1'b1;
        do_cmd(32'h0000_0100, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 0, 16'h0000, 16'h0002, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_0000;
        cmd_read  = 1'b1;
        @(negedge clk);
        chk("inrst_strobes",   64'({per_we, per_rd}), 64'd0);
        chk("inrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("inrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        rst_n       = 1'b1;
        per_wait[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
        end
        do_cmd(32'h0000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 2, 16'h0000, 16'h0001, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
